// File: rtl/fpu_issue_ctrl.sv
// FPU issue/writeback controller: issues one multi-cycle FPU op at a time,
// writes its result to the FP register file and raises decode/execute stalls.
// Latency: FpuStart is same-cycle with issue; the FP result is written in the
// FpuDone cycle, or later if an FLW writeback holds the write port.
// Backpressure: FLW writebacks always win the write port; a colliding FPU
// result waits in HOLD. StallD covers RAW/WAW on the pending destination and
// the single FPU; StallE freezes execute only for integer-destination ops.
module fpu_issue_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  // decode stage
  input  logic        FPUEnableD,
  input  logic [1:0]  FRegReadD,
  input  logic [4:0]  Rs1D,
  input  logic [4:0]  Rs2D,
  input  logic [4:0]  RdD,
  input  logic        FRegWriteD,
  // execute stage
  input  logic        FPUEnableE,
  input  logic        FRegWriteE,
  input  logic [4:0]  RdE,
  input  logic        FlushE,
  // multi-cycle FPU
  output logic        FpuStart,
  input  logic        FpuDone,
  input  logic [31:0] FpuResult,
  // FLW writeback request
  input  logic        MemFRegWriteW,
  input  logic [4:0]  MemRdW,
  input  logic [31:0] MemDataW,
  // FP register-file write port
  output logic        FRegWE,
  output logic [4:0]  FRegWA,
  output logic [31:0] FRegWD,
  // hazard outputs
  output logic        StallD,
  output logic        StallE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_pend_rd;
  logic        r_pend_fp;
  logic [31:0] r_hold_data;

  logic        w_idle;
  logic        w_busy;
  logic        w_hold;
  logic        w_issue;
  logic        w_done_fp;
  logic        w_fpu_wr;
  logic        w_hold_wr;
  logic        w_pv;
  logic [4:0]  w_prd;
  logic        w_raw1;
  logic        w_raw2;
  logic        w_waw;
  logic        w_struct;

  assign w_idle = (r_state == S_IDLE);
  assign w_busy = (r_state == S_BUSY);
  assign w_hold = (r_state == S_HOLD);

  // Only one op in flight; a flushed execute-stage op never reaches the FPU.
  // Holding rst_n low also blocks issue so nothing escapes during reset.
  assign w_issue = rst_n & FPUEnableE & ~FlushE & w_idle;

  // FP-destination result arriving this cycle.
  assign w_done_fp = w_busy & FpuDone & r_pend_fp;

  // The FPU result may use the port only when no FLW writeback claims it.
  assign w_fpu_wr  = w_done_fp & ~MemFRegWriteW;
  assign w_hold_wr = w_hold & ~MemFRegWriteW;

  // Pending FP destination: the op issuing now, otherwise the in-flight one.
  // It stays pending through its write cycle because there is no bypass.
  assign w_pv  = (w_issue & FRegWriteE) | (~w_idle & r_pend_fp);
  assign w_prd = w_issue ? RdE : r_pend_rd;

  assign w_raw1   = w_pv & FRegReadD[1] & (Rs1D == w_prd);
  assign w_raw2   = w_pv & FRegReadD[0] & (Rs2D == w_prd);
  assign w_waw    = w_pv & FRegWriteD & (RdD == w_prd);
  assign w_struct = FPUEnableD & (~w_idle | w_issue);

  // State register with synchronous reset; reset aborts any in-flight op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: FlushE is deliberately ignored once an op is in flight.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) begin
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        if (FpuDone) begin
          if (r_pend_fp && MemFRegWriteW) begin
            w_state_nxt = S_HOLD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (!MemFRegWriteW) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture the destination at issue and park a result blocked by an FLW.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pend_rd   <= 5'd0;
      r_pend_fp   <= 1'b0;
      r_hold_data <= 32'd0;
    end else begin
      if (w_issue) begin
        r_pend_rd <= RdE;
        r_pend_fp <= FRegWriteE;
      end
      if (w_done_fp && MemFRegWriteW) begin
        r_hold_data <= FpuResult;
      end
    end
  end

  // Outputs: start strobe, stalls and write-port mux (FLW first), all forced
  // quiet while reset is asserted.
  always_comb begin
    FpuStart = 1'b0;
    StallD   = 1'b0;
    StallE   = 1'b0;
    FRegWE   = 1'b0;
    FRegWA   = 5'd0;
    FRegWD   = 32'd0;
    if (rst_n) begin
      FpuStart = w_issue;
      // Integer-destination ops block execute until the result is back.
      StallE   = (w_issue & ~FRegWriteE) | (w_busy & ~r_pend_fp & ~FpuDone);
      StallD   = w_raw1 | w_raw2 | w_waw | w_struct;
      if (MemFRegWriteW) begin
        FRegWE = 1'b1;
        FRegWA = MemRdW;
        FRegWD = MemDataW;
      end else if (w_fpu_wr) begin
        FRegWE = 1'b1;
        FRegWA = r_pend_rd;
        FRegWD = FpuResult;
      end else if (w_hold_wr) begin
        FRegWE = 1'b1;
        FRegWA = r_pend_rd;
        FRegWD = r_hold_data;
      end
    end
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl: hand-computed expectations per cycle.
// Inputs change 1ns after the rising edge; outputs are checked 2ns later.
// Each vector exercises one scenario of issue, writeback, stall or reset.
module tb_fpu_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        FPUEnableD;
  logic [1:0]  FRegReadD;
  logic [4:0]  Rs1D;
  logic [4:0]  Rs2D;
  logic [4:0]  RdD;
  logic        FRegWriteD;
  logic        FPUEnableE;
  logic        FRegWriteE;
  logic [4:0]  RdE;
  logic        FlushE;
  logic        FpuStart;
  logic        FpuDone;
  logic [31:0] FpuResult;
  logic        MemFRegWriteW;
  logic [4:0]  MemRdW;
  logic [31:0] MemDataW;
  logic        FRegWE;
  logic [4:0]  FRegWA;
  logic [31:0] FRegWD;
  logic        StallD;
  logic        StallE;

  int checks = 0;
  int errors = 0;

  fpu_issue_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .FPUEnableD    (FPUEnableD),
    .FRegReadD     (FRegReadD),
    .Rs1D          (Rs1D),
    .Rs2D          (Rs2D),
    .RdD           (RdD),
    .FRegWriteD    (FRegWriteD),
    .FPUEnableE    (FPUEnableE),
    .FRegWriteE    (FRegWriteE),
    .RdE           (RdE),
    .FlushE        (FlushE),
    .FpuStart      (FpuStart),
    .FpuDone       (FpuDone),
    .FpuResult     (FpuResult),
    .MemFRegWriteW (MemFRegWriteW),
    .MemRdW        (MemRdW),
    .MemDataW      (MemDataW),
    .FRegWE        (FRegWE),
    .FRegWA        (FRegWA),
    .FRegWD        (FRegWD),
    .StallD        (StallD),
    .StallE        (StallE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after input changes
  task automatic settle();
    #2;
  endtask

  task automatic clr_inputs();
    FPUEnableD    = 1'b0;
    FRegReadD     = 2'b00;
    Rs1D          = 5'd0;
    Rs2D          = 5'd0;
    RdD           = 5'd0;
    FRegWriteD    = 1'b0;
    FPUEnableE    = 1'b0;
    FRegWriteE    = 1'b0;
    RdE           = 5'd0;
    FlushE        = 1'b0;
    FpuDone       = 1'b0;
    FpuResult     = 32'd0;
    MemFRegWriteW = 1'b0;
    MemRdW        = 5'd0;
    MemDataW      = 32'd0;
  endtask

  task automatic issue_op(input logic fp, input logic [4:0] rd);
    FPUEnableE = 1'b1;
    FRegWriteE = fp;
    RdE        = rd;
  endtask

  task automatic end_issue();
    FPUEnableE = 1'b0;
    FRegWriteE = 1'b0;
    RdE        = 5'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clr_inputs();
    rst_n = 1'b0;

    // ---------------- reset with busy inputs ----------------
    FPUEnableE = 1'b1; FPUEnableD = 1'b1;
    MemFRegWriteW = 1'b1; MemRdW = 5'd3; MemDataW = 32'h1234_5678;
    tick(); tick();
    settle();
    chk("rst_start",  {31'd0, FpuStart}, 32'd0);
    chk("rst_we",     {31'd0, FRegWE},   32'd0);
    chk("rst_wa",     {27'd0, FRegWA},   32'd0);
    chk("rst_stalld", {31'd0, StallD},   32'd0);
    chk("rst_stalle", {31'd0, StallE},   32'd0);
    clr_inputs();
    rst_n = 1'b1;
    tick();

    // ---------------- FP op rd5, done after 4 cycles ----------------
    issue_op(1'b1, 5'd5);
    FRegReadD = 2'b01; Rs2D = 5'd5;
    settle();
    chk("fp_start",      {31'd0, FpuStart}, 32'd1);
    chk("fp_stalle",     {31'd0, StallE},   32'd0);
    chk("fp_raw_issue",  {31'd0, StallD},   32'd1);
    tick();
    end_issue();
    settle();
    chk("fp_start_once", {31'd0, FpuStart}, 32'd0);
    chk("fp_raw_busy",   {31'd0, StallD},   32'd1);
    chk("fp_we_busy",    {31'd0, FRegWE},   32'd0);
    tick();
    Rs2D = 5'd6;
    settle();
    chk("fp_noraw_rs6",  {31'd0, StallD},   32'd0);
    tick();
    FRegReadD = 2'b00; FRegWriteD = 1'b1; RdD = 5'd5;
    settle();
    chk("fp_waw",        {31'd0, StallD},   32'd1);
    tick();
    FRegWriteD = 1'b0; RdD = 5'd0;
    FRegReadD = 2'b01; Rs2D = 5'd5;
    FpuDone = 1'b1; FpuResult = 32'hDEAD_BEEF;
    settle();
    chk("fp_done_we",    {31'd0, FRegWE},   32'd1);
    chk("fp_done_wa",    {27'd0, FRegWA},   32'd5);
    chk("fp_done_wd",    FRegWD,            32'hDEAD_BEEF);
    chk("fp_done_stalld",{31'd0, StallD},   32'd1);
    tick();
    FpuDone = 1'b0; FpuResult = 32'd0;
    settle();
    chk("fp_after_we",   {31'd0, FRegWE},   32'd0);
    chk("fp_after_wd",   FRegWD,            32'd0);
    chk("fp_after_stalld",{31'd0, StallD},  32'd0);
    FRegReadD = 2'b00; Rs2D = 5'd0;

    // flushed op must not issue
    FPUEnableE = 1'b1; FlushE = 1'b1;
    settle();
    chk("flush_nostart", {31'd0, FpuStart}, 32'd0);
    tick();
    FPUEnableE = 1'b0; FlushE = 1'b0; FPUEnableD = 1'b1;
    settle();
    chk("flush_idle",    {31'd0, StallD},   32'd0);
    FPUEnableD = 1'b0;

    // ---------------- FpuDone collides with FLW rd7 ----------------
    issue_op(1'b1, 5'd5);
    tick();
    end_issue();
    FRegReadD = 2'b10; Rs1D = 5'd5;
    settle();
    chk("col_raw_rs1",   {31'd0, StallD},   32'd1);
    FRegReadD = 2'b00; Rs1D = 5'd0;
    tick();
    FpuDone = 1'b1; FpuResult = 32'h1111_2222;
    MemFRegWriteW = 1'b1; MemRdW = 5'd7; MemDataW = 32'hAAAA_5555;
    settle();
    chk("col_flw_we",    {31'd0, FRegWE},   32'd1);
    chk("col_flw_wa",    {27'd0, FRegWA},   32'd7);
    chk("col_flw_wd",    FRegWD,            32'hAAAA_5555);
    tick();
    FpuDone = 1'b0; FpuResult = 32'd0;
    MemFRegWriteW = 1'b0; MemRdW = 5'd0; MemDataW = 32'd0;
    settle();
    chk("col_hold_we",   {31'd0, FRegWE},   32'd1);
    chk("col_hold_wa",   {27'd0, FRegWA},   32'd5);
    chk("col_hold_wd",   FRegWD,            32'h1111_2222);
    tick();
    FPUEnableD = 1'b1;
    settle();
    chk("col_idle_we",   {31'd0, FRegWE},   32'd0);
    chk("col_idle_stalld",{31'd0, StallD},  32'd0);
    FPUEnableD = 1'b0;

    // ---------------- HOLD with 3 consecutive FLWs ----------------
    issue_op(1'b1, 5'd9);
    tick();
    end_issue();
    FpuDone = 1'b1; FpuResult = 32'hCAFE_F00D;
    MemFRegWriteW = 1'b1; MemRdW = 5'd1; MemDataW = 32'h0000_0A01;
    settle();
    chk("hold_d_wa",     {27'd0, FRegWA},   32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      FpuDone = 1'b0; FpuResult = 32'h5A5A_0000 + i;
      MemRdW = 5'(10 + i); MemDataW = 32'h0000_0B00 + i;
      FPUEnableE = 1'b1; FlushE = 1'b1; FPUEnableD = 1'b1;
      settle();
      chk("hold_flw_wa",   {27'd0, FRegWA},   32'(10 + i));
      chk("hold_flw_wd",   FRegWD,            32'h0000_0B00 + i);
      chk("hold_nostart",  {31'd0, FpuStart}, 32'd0);
      chk("hold_struct",   {31'd0, StallD},   32'd1);
    end
    tick();
    FPUEnableE = 1'b0; FlushE = 1'b0; FPUEnableD = 1'b0;
    MemFRegWriteW = 1'b0; MemRdW = 5'd0; MemDataW = 32'd0; FpuResult = 32'd0;
    settle();
    chk("hold_rel_we",   {31'd0, FRegWE},   32'd1);
    chk("hold_rel_wa",   {27'd0, FRegWA},   32'd9);
    chk("hold_rel_wd",   FRegWD,            32'hCAFE_F00D);
    tick();

    // ---------------- integer-destination op, 6-cycle latency ----------------
    issue_op(1'b0, 5'd3);
    FRegWriteD = 1'b1; RdD = 5'd3;
    settle();
    chk("int_start",     {31'd0, FpuStart}, 32'd1);
    chk("int_stalle_0",  {31'd0, StallE},   32'd1);
    chk("int_nowaw",     {31'd0, StallD},   32'd0);
    for (int i = 1; i < 6; i++) begin
      tick();
      end_issue();
      settle();
      chk("int_stalle",    {31'd0, StallE},   32'd1);
      chk("int_we",        {31'd0, FRegWE},   32'd0);
    end
    tick();
    FRegWriteD = 1'b0; RdD = 5'd0;
    FpuDone = 1'b1; FpuResult = 32'h0000_0077;
    issue_op(1'b1, 5'd4);
    settle();
    chk("int_done_stalle",{31'd0, StallE},  32'd0);
    chk("int_done_we",   {31'd0, FRegWE},   32'd0);
    chk("int_no_b2b",    {31'd0, FpuStart}, 32'd0);
    tick();
    FpuDone = 1'b0; FpuResult = 32'd0;
    settle();
    chk("b2b_start",     {31'd0, FpuStart}, 32'd1);
    tick();
    end_issue();

    // ---------------- reset during BUSY, late FpuDone ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    FpuDone = 1'b1; FpuResult = 32'hBAD0_BAD0;
    settle();
    chk("rstb_we",       {31'd0, FRegWE},   32'd0);
    chk("rstb_start",    {31'd0, FpuStart}, 32'd0);
    tick();
    FpuDone = 1'b0; FpuResult = 32'd0;
    FPUEnableE = 1'b1;
    settle();
    chk("rstb_idle",     {31'd0, FpuStart}, 32'd1);
    tick();
    clr_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-003 SHALL have inputs FPUEnableD (1), FRegReadD (2: bit1 rs1 is FP, bit0 rs2 is FP), Rs1D, Rs2D, RdD (5 each), FRegWriteD (1): decode-stage operand and destination info.
REQ-004 SHALL have inputs FPUEnableE (1), FRegWriteE (1), RdE (5), FlushE (1): the execute-stage FPU op and its flush.
REQ-005 SHALL have output FpuStart (1), the start strobe to the multi-cycle FPU; inputs FpuDone (1) and FpuResult (32) from the FPU.
REQ-006 SHALL have inputs MemFRegWriteW (1), MemRdW (5), MemDataW (32): FLW writeback request.
REQ-007 SHALL have outputs FRegWE (1), FRegWA (5), FRegWD (32): the single FP register-file write port.
REQ-008 SHALL have outputs StallD (1) and StallE (1) to the hazard logic.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY, HOLD; registers pend_rd[4:0], pend_fp, hold_data[31:0].
REQ-010 issue = FPUEnableE & ~FlushE & state==IDLE; FpuStart SHALL equal issue, combinationally, for exactly one cycle per op.
REQ-011 On issue, the block SHALL capture pend_rd<=RdE and pend_fp<=FRegWriteE, and go to BUSY next cycle.
REQ-012 FPUEnableE with FlushE high SHALL NOT issue, and SHALL leave state and FpuStart unchanged.
REQ-013 In IDLE, FpuDone SHALL be ignored.
REQ-014 In BUSY with pend_fp=1 and FpuDone:
- if MemFRegWriteW=0, SHALL write FpuResult to pend_rd that cycle and go to IDLE;
- otherwise, SHALL latch FpuResult into hold_data and go to HOLD.
REQ-015 In HOLD, SHALL write hold_data to pend_rd on the first cycle with MemFRegWriteW=0, then go to IDLE.
REQ-016 MemFRegWriteW SHALL always own the write port when asserted: FRegWE=1, FRegWA=MemRdW, FRegWD=MemDataW. The FLW writeback is never delayed.
REQ-017 Integer-destination FPU op (pend_fp=0):
- StallE SHALL be high from the issue cycle through the last BUSY cycle before FpuDone, and low in the FpuDone cycle;
- the state SHALL go to IDLE on FpuDone;
- the FP write port SHALL NOT be used.
REQ-018 StallE SHALL be 0 for FP-destination ops. These are non-blocking.
REQ-019 Pending destination: pv = issue | (state!=IDLE & pend_fp), and prd = issue ? RdE : pend_rd. For issue, pv SHALL use FRegWriteE.
REQ-020 StallD SHALL be 1 when any of the following holds:
- pv & FRegReadD[1] & Rs1D==prd;
- pv & FRegReadD[0] & Rs2D==prd;
- pv & FRegWriteD & RdD==prd (WAW);
- FPUEnableD & (state!=IDLE | issue) (structural).
REQ-021 A new op SHALL NOT issue in the completion cycle; the earliest back-to-back issue is the cycle after the state returns to IDLE.
REQ-022 When FRegWE=0, FRegWA and FRegWD SHALL be 0.
REQ-023 A FlushE arriving while BUSY or HOLD SHALL NOT cancel the in-flight op.

Reset
REQ-024 With rst_n=0 at a rising edge:
- state<=IDLE; pend_rd, pend_fp, hold_data <= 0;
- FpuStart, FRegWE, StallD, StallE SHALL be 0 from the cycle after, regardless of the other inputs.
REQ-025 Reset SHALL abort a BUSY or HOLD op. FpuDone arriving after reset SHALL be ignored.

Verification
REQ-026 FP op, RdE=5, FpuDone 4 cycles later, no FLW -> FpuStart one cycle; FRegWE=1, FRegWA=5, FRegWD=FpuResult in the done cycle; then IDLE.
REQ-027 FpuDone coincides with MemFRegWriteW, MemRdW=7 -> port writes rd7 MemDataW; the next cycle writes rd5 hold_data.
REQ-028 HOLD with MemFRegWriteW high for 3 consecutive cycles -> hold_data written on cycle 4; no FRegWD corruption.
REQ-029 Pending rd=5, decode Rs2D=5 with FRegReadD=01 -> StallD=1 until the write cycle; Rs2D=6 -> StallD=0.
REQ-030 Integer-destination op with 6-cycle latency -> StallE high for 6 cycles, low on FpuDone; FRegWE stays 0.
REQ-031 rst_n low during BUSY, FpuDone pulsed the cycle after release -> no write, FSM stays IDLE, FpuStart=0.
